// File: rtl/register_stack.sv
// Parametrised LIFO of WIDTH-bit registers with push/pop/replace, depth status,
// sticky over/underflow flags and an optional circular-overwrite (WRAP) mode.
module register_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter bit WRAP  = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in,
  input  logic                       nPush,
  input  logic                       nPop,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    OP_REPLACE = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_IDLE    = 2'b11
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, top_ptr, waddr;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             we, is_empty, is_full;

  // Storage is circular, so both pointer steps wrap at DEPTH (not a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_LAST : p - 1'b1;
  endfunction

  assign op       = op_e'({nPush, nPop});
  assign top_ptr  = ptr_dec(wr_ptr_q);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_FULL);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    we       = 1'b0;
    waddr    = wr_ptr_q;
    unique case (op)
      OP_PUSH: begin
        if (!is_full) begin
          we       = 1'b1;
          wr_ptr_d = ptr_inc(wr_ptr_q);
          count_d  = count_q + 1'b1;
        end else if (WRAP) begin
          // When full, the write slot is the oldest entry: overwrite it.
          we       = 1'b1;
          wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
          ovf_d = 1'b1;
        end
      end
      OP_POP: begin
        if (!is_empty) begin
          wr_ptr_d = top_ptr;
          count_d  = count_q - 1'b1;
        end else begin
          unf_d = 1'b1;
        end
      end
      OP_REPLACE: begin
        we = 1'b1;
        if (!is_empty) begin
          waddr = top_ptr;
        end else begin
          wr_ptr_d = ptr_inc(wr_ptr_q);
          count_d  = CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; count gates what is visible.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem_q[waddr] <= in;
    end
  end

  assign out       = is_empty ? '0 : mem_q[top_ptr];
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_register_stack.sv
// Drives a WRAP=0 and a WRAP=1 stack with the same stimulus and compares both
// against queue-based reference models, directed scenarios first, then random.
module tb_register_stack;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset, nPush, nPop;
  logic [WIDTH-1:0] in;

  logic [WIDTH-1:0] out_n, out_w;
  logic [CNT_W-1:0] count_n, count_w;
  logic             empty_n, empty_w, full_n, full_w;
  logic             ovf_n, ovf_w, unf_n, unf_w;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] q [2][$];
  bit               ovf_m [2];
  bit               unf_m [2];

  always #5 clk = ~clk;

  register_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRAP(1'b0)) u_nowrap (
    .clk(clk), .reset(reset), .in(in), .nPush(nPush), .nPop(nPop),
    .out(out_n), .count(count_n), .empty(empty_n), .full(full_n),
    .overflow(ovf_n), .underflow(unf_n)
  );

  register_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .in(in), .nPush(nPush), .nPop(nPop),
    .out(out_w), .count(count_w), .empty(empty_w), .full(full_w),
    .overflow(ovf_w), .underflow(unf_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a queue holding the live entries, oldest at index 0.
  task automatic model_step(input bit rst, input bit np, input bit npp, input logic [WIDTH-1:0] d);
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        q[m].delete();
        ovf_m[m] = 1'b0;
        unf_m[m] = 1'b0;
      end else begin
        case ({np, npp})
          2'b01: begin
            if (q[m].size() < DEPTH) q[m].push_back(d);
            else if (m == 1) begin
              q[m].delete(0);
              q[m].push_back(d);
            end else ovf_m[m] = 1'b1;
          end
          2'b10: begin
            if (q[m].size() > 0) q[m].delete(q[m].size() - 1);
            else unf_m[m] = 1'b1;
          end
          2'b00: begin
            if (q[m].size() > 0) q[m][q[m].size() - 1] = d;
            else q[m].push_back(d);
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_all(input string step);
    logic [WIDTH-1:0] exp_out [2];
    for (int m = 0; m < 2; m++)
      exp_out[m] = (q[m].size() > 0) ? q[m][q[m].size() - 1] : '0;
    check({step, " nowrap.out"},   32'(out_n),   32'(exp_out[0]));
    check({step, " nowrap.count"}, 32'(count_n), 32'(q[0].size()));
    check({step, " nowrap.empty"}, 32'(empty_n), 32'(q[0].size() == 0));
    check({step, " nowrap.full"},  32'(full_n),  32'(q[0].size() == DEPTH));
    check({step, " nowrap.ovf"},   32'(ovf_n),   32'(ovf_m[0]));
    check({step, " nowrap.unf"},   32'(unf_n),   32'(unf_m[0]));
    check({step, " wrap.out"},     32'(out_w),   32'(exp_out[1]));
    check({step, " wrap.count"},   32'(count_w), 32'(q[1].size()));
    check({step, " wrap.empty"},   32'(empty_w), 32'(q[1].size() == 0));
    check({step, " wrap.full"},    32'(full_w),  32'(q[1].size() == DEPTH));
    check({step, " wrap.ovf"},     32'(ovf_w),   32'(ovf_m[1]));
    check({step, " wrap.unf"},     32'(unf_w),   32'(unf_m[1]));
  endtask

  task automatic cycle(input string step, input bit rst, input bit np, input bit npp,
                       input logic [WIDTH-1:0] d);
    reset = rst;
    nPush = np;
    nPop  = npp;
    in    = d;
    @(posedge clk);
    model_step(rst, np, npp, d);
    #1;
    check_all(step);
  endtask

  task automatic push(input string step, input logic [WIDTH-1:0] d);
    cycle(step, 1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic pop(input string step);
    cycle(step, 1'b0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    bit               r_rst, r_np, r_npp;
    logic [WIDTH-1:0] r_d;

    // Reset held for two cycles.
    cycle("reset0", 1'b1, 1'b1, 1'b1, '0);
    cycle("reset1", 1'b1, 1'b1, 1'b1, '0);
    check("reset.out.const",   32'(out_n),   32'h0);
    check("reset.count.const", 32'(count_n), 32'h0);

    // Fill then drain.
    push("fill", 4'h3); push("fill", 4'h5); push("fill", 4'h9); push("fill", 4'hC);
    check("fill.full.const", 32'(full_n), 32'h1);
    pop("drain"); pop("drain"); pop("drain"); pop("drain");
    check("drain.empty.const", 32'(empty_n), 32'h1);

    // Push while full, then drain; also wrap on the second instance.
    cycle("rst2", 1'b1, 1'b1, 1'b1, '0);
    for (int i = 1; i <= 4; i++) push("full", WIDTH'(i));
    push("ovf", 4'h7);
    check("ovf.nowrap.out.const", 32'(out_n), 32'h4);
    check("ovf.wrap.out.const",   32'(out_w), 32'h7);
    for (int i = 0; i < 4; i++) pop("ovf.drain");

    // Wrap after six pushes: the last four remain.
    cycle("rst3", 1'b1, 1'b1, 1'b1, '0);
    for (int i = 1; i <= 6; i++) push("wrap", WIDTH'(i));
    check("wrap.out.const", 32'(out_w), 32'h6);
    for (int i = 0; i < 4; i++) pop("wrap.drain");

    // Underflow, push then replace, replace on empty.
    cycle("rst4", 1'b1, 1'b1, 1'b1, '0);
    pop("underflow");
    push("pushA", 4'hA);
    cycle("replB", 1'b0, 1'b0, 1'b0, 4'hB);
    check("replB.out.const", 32'(out_n), 32'hB);
    pop("popB");
    cycle("repl_empty", 1'b0, 1'b0, 1'b0, 4'h2);
    cycle("idle", 1'b0, 1'b1, 1'b1, 4'hF);

    // Push with reset in the same cycle; flags clear too.
    for (int i = 0; i < 5; i++) push("preovf", 4'h8);
    cycle("push_rst", 1'b1, 1'b0, 1'b1, 4'h3);
    check("push_rst.count.const", 32'(count_n), 32'h0);

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      r_rst = ($urandom_range(0, 59) == 0);
      r_np  = 1'($urandom);
      r_npp = 1'($urandom);
      r_d   = WIDTH'($urandom);
      cycle("rand", r_rst, r_np, r_npp, r_d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
